// File: rtl/xor_cipher_defs.sv
// rtl/xor_cipher_defs.sv - shared XOR cipher link defaults and FSM state encodings
package xor_cipher_defs;

    localparam int KEY_SIZE_DEF = 32;
    localparam int MSG_SIZE_DEF = 512;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RECV  = 2'd2
    } link_state_t;

endpackage

// File: rtl/xor_byte_fifo.sv
// rtl/xor_byte_fifo.sv - small byte FIFO with same-cycle push/pop and drop flag
module xor_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = ena && pop && !empty;
    assign do_push = ena && push && (!full || do_pop);
    assign drop    = ena && push && !do_push;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/xor_stream_decrypt.sv
// rtl/xor_stream_decrypt.sv - serial XOR cipher receiver: key loader, framing FSM, byte packer
module xor_stream_decrypt
    import xor_cipher_defs::*;
#(
    parameter int KEY_SIZE   = KEY_SIZE_DEF,
    parameter int MSG_SIZE   = MSG_SIZE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                iKey_bit,
    input  logic                iKey_load,
    input  logic                iSer_data,
    input  logic                iSer_start,
    input  logic                iSer_end,
    output logic [BYTE_W-1:0]   oByte,
    output logic                oByte_valid,
    input  logic                iByte_ready,
    output logic                oKey_ready,
    output logic                oFrame_done,
    output logic                oFrame_err,
    output logic                oOverflow
);

    localparam int KIW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam int KCW = $clog2(KEY_SIZE + 1);
    localparam int BW  = $clog2(MSG_SIZE) + 1;

    link_state_t        state;
    link_state_t        state_nxt;
    logic [KEY_SIZE-1:0] key;
    logic [KCW-1:0]     key_cnt;
    logic [KIW-1:0]     key_idx;
    logic [BW-1:0]      bit_cnt;
    logic [BYTE_W-1:0]  byte_sr;

    logic               key_wr;
    logic               accept;
    logic               restart;
    logic               shift;
    logic               close_ok;
    logic               set_err;
    logic               first_bit;
    logic [KIW-1:0]     cur_idx;
    logic               plain_bit;
    logic [BYTE_W-1:0]  packed_byte;
    logic               last_bit;
    logic               push;
    logic               fifo_empty;
    logic               fifo_drop;
    logic [BYTE_W-1:0]  fifo_head;

    assign first_bit   = accept || restart;
    assign cur_idx     = first_bit ? '0 : key_idx;
    assign plain_bit   = iSer_data ^ key[cur_idx];
    assign packed_byte = {plain_bit, byte_sr[BYTE_W-1:1]};
    assign last_bit    = (bit_cnt == BW'(MSG_SIZE - 1));
    assign push        = shift && (bit_cnt[2:0] == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_wr    = 1'b0;
        accept    = 1'b0;
        restart   = 1'b0;
        shift     = 1'b0;
        close_ok  = 1'b0;
        set_err   = 1'b0;
        if (ena) begin
            unique case (state)
                ST_IDLE: begin
                    set_err = iSer_start;
                    if (iKey_load) begin
                        key_wr = 1'b1;
                    end else if (oKey_ready) begin
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // A start wins over a simultaneous key reload so the key stays stable for the frame.
                    if (iSer_start) begin
                        accept    = 1'b1;
                        state_nxt = ST_RECV;
                    end else if (iKey_load) begin
                        key_wr    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (iSer_start) begin
                        restart = 1'b1;
                        set_err = 1'b1;
                    end else if (last_bit) begin
                        shift     = 1'b1;
                        close_ok  = iSer_end;
                        set_err   = !iSer_end;
                        state_nxt = ST_ARMED;
                    end else if (iSer_end) begin
                        set_err   = 1'b1;
                        state_nxt = ST_ARMED;
                    end else begin
                        shift = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key         <= '0;
            key_cnt     <= '0;
            oKey_ready  <= 1'b0;
            key_idx     <= '0;
            bit_cnt     <= '0;
            byte_sr     <= '0;
            oFrame_done <= 1'b0;
            oFrame_err  <= 1'b0;
            oOverflow   <= 1'b0;
        end else begin
            if (key_wr) begin
                // A load after a complete key starts a fresh key at bit 0.
                if (oKey_ready) begin
                    key[0]     <= iKey_bit;
                    key_cnt    <= KCW'(1);
                    oKey_ready <= (KEY_SIZE == 1);
                end else begin
                    key[key_cnt[KIW-1:0]] <= iKey_bit;
                    key_cnt               <= key_cnt + KCW'(1);
                    if (key_cnt == KCW'(KEY_SIZE - 1)) begin
                        oKey_ready <= 1'b1;
                    end
                end
            end
            if (first_bit || shift) begin
                byte_sr <= packed_byte;
                bit_cnt <= first_bit ? BW'(1) : bit_cnt + BW'(1);
                key_idx <= (cur_idx == KIW'(KEY_SIZE - 1)) ? '0 : cur_idx + KIW'(1);
            end
            if (ena) begin
                oFrame_done <= close_ok;
            end
            if (accept) begin
                oFrame_err <= 1'b0;
            end else if (set_err) begin
                oFrame_err <= 1'b1;
            end
            if (fifo_drop) begin
                oOverflow <= 1'b1;
            end
        end
    end

    xor_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .push      (push),
        .push_data (packed_byte),
        .pop       (iByte_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign oByte_valid = !fifo_empty;
    assign oByte       = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// tb/tb_xor_stream_decrypt.sv - directed scoreboard bench for xor_stream_decrypt
module tb_xor_stream_decrypt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       iKey_bit;
    logic       iKey_load;
    logic       iSer_data;
    logic       iSer_start;
    logic       iSer_end;
    logic [7:0] oByte;
    logic       oByte_valid;
    logic       iByte_ready;
    logic       oKey_ready;
    logic       oFrame_done;
    logic       oFrame_err;
    logic       oOverflow;

    int         n_vec = 0;
    int         n_err = 0;
    int         done_total = 0;
    int         done_base;
    logic [7:0] exp_q [$];
    logic [7:0] cipher [64];
    logic [31:0] key_v;

    always #5 clk = ~clk;

    xor_stream_decrypt dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .iKey_bit    (iKey_bit),
        .iKey_load   (iKey_load),
        .iSer_data   (iSer_data),
        .iSer_start  (iSer_start),
        .iSer_end    (iSer_end),
        .oByte       (oByte),
        .oByte_valid (oByte_valid),
        .iByte_ready (iByte_ready),
        .oKey_ready  (oKey_ready),
        .oFrame_done (oFrame_done),
        .oFrame_err  (oFrame_err),
        .oOverflow   (oOverflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] plain(input int k);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = cipher[k][i] ^ key_v[(8 * k + i) % 32];
        end
        return p;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && oFrame_done) done_total++;
            if (rst_n && ena && oByte_valid && iByte_ready) begin
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL extra_byte: observed %02h expected no byte", oByte);
                end
                if (exp_q.size() != 0) check("byte", {24'b0, oByte}, {24'b0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic load_key(input logic [31:0] k, input int first, input int last);
        key_v = k;
        for (int i = first; i <= last; i++) begin
            iKey_load = 1'b1;
            iKey_bit  = k[i];
            cyc();
        end
        iKey_load = 1'b0;
        iKey_bit  = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic send_range(input int first, input int last, input int end_at, input int limit);
        for (int j = first; j <= last; j++) begin
            iSer_data  = cipher[j / 8][j % 8];
            iSer_start = (j == 0);
            iSer_end   = (j == end_at);
            if ((j % 8 == 7) && (j / 8 < limit)) exp_q.push_back(plain(j / 8));
            cyc();
        end
        iSer_data  = 1'b0;
        iSer_start = 1'b0;
        iSer_end   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, oByte_valid, 0);
        check({tag, "_byte"},  oByte, 0);
        check({tag, "_keyrdy"}, oKey_ready, 0);
        check({tag, "_done"},  oFrame_done, 0);
        check({tag, "_err"},   oFrame_err, 0);
        check({tag, "_ovf"},   oOverflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; iKey_bit = 1'b0; iKey_load = 1'b0;
        iSer_data = 1'b0; iSer_start = 1'b0; iSer_end = 1'b0; iByte_ready = 1'b0;
        fork
            monitor();
        join_none
        cyc();
        cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // 1: key 0x000000FF, all 0x3C ciphertext
        load_key(32'h0000_00FF, 0, 31);
        check("t1_keyrdy", oKey_ready, 1);
        foreach (cipher[k]) cipher[k] = 8'h3C;
        check("t1_model", {24'b0, plain(0)}, 32'hC3);
        iByte_ready = 1'b1;
        done_base = done_total;
        send_range(0, 511, 511, 64);
        repeat (6) cyc();
        check("t1_drained", exp_q.size(), 0);
        check("t1_done", done_total - done_base, 1);
        check("t1_err", oFrame_err, 0);

        // 2: key all ones, byte k = k, push-to-valid latency, ena hold
        load_key(32'hFFFF_FFFF, 0, 31);
        foreach (cipher[k]) cipher[k] = 8'(k);
        done_base = done_total;
        send_range(0, 6, 511, 64);
        check("t2_valid_before", oByte_valid, 0);
        send_range(7, 7, 511, 64);
        check("t2_valid_after", oByte_valid, 1);
        check("t2_byte0", oByte, 8'hFF);
        ena = 1'b0;
        iSer_start = 1'b1;
        iSer_data  = 1'b1;
        repeat (3) cyc();
        iSer_start = 1'b0;
        check("t2_ena_hold_valid", oByte_valid, 1);
        check("t2_ena_hold_byte", oByte, 8'hFF);
        check("t2_ena_hold_err", oFrame_err, 0);
        ena = 1'b1;
        send_range(8, 511, 511, 64);
        repeat (6) cyc();
        check("t2_drained", exp_q.size(), 0);
        check("t2_done", done_total - done_base, 1);

        // 3: consumer stalled for the whole frame
        iByte_ready = 1'b0;
        foreach (cipher[k]) cipher[k] = 8'($urandom);
        done_base = done_total;
        send_range(0, 511, 511, 4);
        cyc();
        check("t3_ovf", oOverflow, 1);
        check("t3_valid", oByte_valid, 1);
        check("t3_done", done_total - done_base, 1);
        iByte_ready = 1'b1;
        repeat (8) cyc();
        check("t3_drained", exp_q.size(), 0);
        check("t3_empty", oByte_valid, 0);

        // 4: early end at bit 100, then a clean frame clears the error
        foreach (cipher[k]) cipher[k] = 8'($urandom);
        done_base = done_total;
        send_range(0, 100, 100, 12);
        repeat (6) cyc();
        check("t4_err", oFrame_err, 1);
        check("t4_nodone", done_total - done_base, 0);
        check("t4_drained", exp_q.size(), 0);
        send_range(0, 0, 511, 64);
        check("t4_err_cleared", oFrame_err, 0);
        send_range(1, 511, 511, 64);
        repeat (6) cyc();
        check("t4_done", done_total - done_base, 1);
        check("t4_drained2", exp_q.size(), 0);

        // 5: start with only 20 key bits loaded
        load_key(32'h9E37_79B9, 0, 19);
        check("t5_keyrdy", oKey_ready, 0);
        send_range(0, 15, -1, 0);
        repeat (3) cyc();
        check("t5_err", oFrame_err, 1);
        check("t5_valid", oByte_valid, 0);
        check("t5_keyrdy_still", oKey_ready, 0);
        load_key(32'h9E37_79B9, 20, 31);
        check("t5_keyrdy_done", oKey_ready, 1);

        // 6: reset in the middle of a frame, then a clean frame with a new key
        foreach (cipher[k]) cipher[k] = 8'($urandom);
        send_range(0, 199, 511, 64);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        repeat (3) cyc();
        check_reset_outputs("t6_rst_hold");
        rst_n = 1'b1;
        cyc();
        load_key(32'h5A3C_96E1, 0, 31);
        foreach (cipher[k]) cipher[k] = 8'($urandom);
        done_base = done_total;
        send_range(0, 511, 511, 64);
        repeat (6) cyc();
        check("t6_drained", exp_q.size(), 0);
        check("t6_done", done_total - done_base, 1);
        check("t6_err", oFrame_err, 0);
        check("t6_ovf", oOverflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
